// File: rtl/fpmac_operand_sequencer_if.sv
// Operand/result bundle between the switch-bank front end and the FPMAC sequencer.
// The sequencer is the slave side; the board logic (or bench) is the master.
interface fpmac_operand_sequencer_if #(
  parameter int SW_W = 16
);
  logic                enterPulse;
  logic                clearPulse;
  logic [SW_W-1:0]     switches;
  logic [2*SW_W-1:0]   macResult;
  logic [2*SW_W-1:0]   opA;
  logic [2*SW_W-1:0]   opB;
  logic                macIssue;
  logic                accClear;
  logic [2*SW_W-1:0]   resultReg;
  logic                resultValid;
  logic                busy;
  logic [2:0]          state;

  modport master (
    output enterPulse, clearPulse, switches, macResult,
    input  opA, opB, macIssue, accClear, resultReg, resultValid, busy, state
  );

  modport slave (
    input  enterPulse, clearPulse, switches, macResult,
    output opA, opB, macIssue, accClear, resultReg, resultValid, busy, state
  );
endinterface

// File: rtl/fpmac_operand_sequencer.sv
// Collects two FP32 operands as four switch halves, issues one MAC, waits LATENCY
// cycles and latches the accumulator for display; clear aborts and zeroes everything.
module fpmac_operand_sequencer #(
  parameter int SW_W    = 16,
  parameter int LATENCY = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  fpmac_operand_sequencer_if.slave  bus
);
  localparam int OP_W  = 2 * SW_W;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LATENCY);

  typedef enum logic [2:0] {
    A_HI  = 3'd0,
    A_LO  = 3'd1,
    B_HI  = 3'd2,
    B_LO  = 3'd3,
    ISSUE = 3'd4,
    WAIT  = 3'd5,
    DONE  = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic [OP_W-1:0]   result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              mac_issue_q, mac_issue_d;
  logic              acc_clear_q, acc_clear_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= A_HI;
      op_a_q         <= '0;
      op_b_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      mac_issue_q    <= 1'b0;
      acc_clear_q    <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      mac_issue_q    <= mac_issue_d;
      acc_clear_q    <= acc_clear_d;
      cnt_q          <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    cnt_d          = cnt_q;
    mac_issue_d    = 1'b0;
    acc_clear_d    = 1'b0;

    // Clear overrides everything, including a simultaneous enter or an in-flight MAC.
    if (bus.clearPulse) begin
      state_d        = A_HI;
      op_a_d         = '0;
      op_b_d         = '0;
      result_d       = '0;
      result_valid_d = 1'b0;
      cnt_d          = '0;
      acc_clear_d    = 1'b1;
    end else begin
      case (state_q)
        A_HI: if (bus.enterPulse) begin
          op_a_d[OP_W-1:SW_W] = bus.switches;
          state_d             = A_LO;
        end
        A_LO: if (bus.enterPulse) begin
          op_a_d[SW_W-1:0] = bus.switches;
          state_d          = B_HI;
        end
        B_HI: if (bus.enterPulse) begin
          op_b_d[OP_W-1:SW_W] = bus.switches;
          state_d             = B_LO;
        end
        B_LO: if (bus.enterPulse) begin
          op_b_d[SW_W-1:0] = bus.switches;
          state_d          = ISSUE;
          mac_issue_d      = 1'b1;
        end
        ISSUE: begin
          cnt_d   = CNT_ONE;
          state_d = WAIT;
        end
        WAIT: begin
          if (cnt_q == CNT_MAX) begin
            result_d       = bus.macResult;
            result_valid_d = 1'b1;
            state_d        = DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DONE: if (bus.enterPulse) begin
          // Accumulator is left alone so successive MACs chain.
          op_a_d[OP_W-1:SW_W] = bus.switches;
          result_valid_d      = 1'b0;
          state_d             = A_LO;
        end
        default: state_d = A_HI;
      endcase
    end
  end

  assign bus.opA         = op_a_q;
  assign bus.opB         = op_b_q;
  assign bus.macIssue    = mac_issue_q;
  assign bus.accClear    = acc_clear_q;
  assign bus.resultReg   = result_q;
  assign bus.resultValid = result_valid_q;
  assign bus.busy        = (state_q == ISSUE) || (state_q == WAIT);
  assign bus.state       = state_q;
endmodule

// File: tb/tb_fpmac_operand_sequencer.sv
// Directed scenarios plus a randomized run against a transaction-level model
// that tracks halves entered, in-flight age and result ownership.
module tb_fpmac_operand_sequencer;
  localparam int SW_W = 16;
  localparam int LAT  = 5;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  fpmac_operand_sequencer_if #(.SW_W(SW_W)) bus();
  fpmac_operand_sequencer #(.SW_W(SW_W), .LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [31:0] m_a, m_b, m_res;
  int          m_halves, m_age;
  bit          m_inflight, m_have, m_issue, m_clr;

  task automatic model_reset();
    m_a = '0; m_b = '0; m_res = '0;
    m_halves = 0; m_age = 0;
    m_inflight = 0; m_have = 0; m_issue = 0; m_clr = 0;
  endtask

  task automatic model_step(input bit e, input bit c, input logic [15:0] sw, input logic [31:0] res);
    m_issue = 0;
    m_clr   = 0;
    if (c) begin
      model_reset();
      m_clr = 1;
    end else if (m_inflight) begin
      if (m_age == LAT) begin
        m_res = res; m_have = 1; m_inflight = 0;
      end else begin
        m_age++;
      end
    end else if (e) begin
      if (m_have) begin m_have = 0; m_halves = 0; end
      case (m_halves)
        0:       m_a[31:16] = sw;
        1:       m_a[15:0]  = sw;
        2:       m_b[31:16] = sw;
        default: m_b[15:0]  = sw;
      endcase
      m_halves++;
      if (m_halves == 4) begin
        m_halves = 0; m_inflight = 1; m_age = 0; m_issue = 1;
      end
    end
  endtask

  function automatic logic [2:0] m_state();
    if (m_have)     return 3'd6;
    if (m_inflight) return (m_age == 0) ? 3'd4 : 3'd5;
    return 3'(m_halves);
  endfunction

  function automatic logic [102:0] m_pack();
    return {m_a, m_b, m_res, m_issue, m_clr, m_have, m_inflight, m_state()};
  endfunction

  function automatic logic [102:0] dut_pack();
    return {bus.opA, bus.opB, bus.resultReg, bus.macIssue, bus.accClear,
            bus.resultValid, bus.busy, bus.state};
  endfunction

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic tick(input bit e, input bit c, input logic [15:0] sw, input logic [31:0] res);
    bus.enterPulse = e; bus.clearPulse = c; bus.switches = sw; bus.macResult = res;
    @(posedge clock);
    model_step(e, c, sw, res);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.enterPulse = 0; bus.clearPulse = 0; bus.switches = '0; bus.macResult = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (dut_pack() !== '0) begin
      failures++; $display("FAIL reset_outputs: got %h expected 0", dut_pack());
    end
    reset = 1'b1;
    tick(0, 0, 16'h0, 32'h0);
    checks++;
    if (bus.state !== 3'd0 || bus.macIssue !== 1'b0) begin
      failures++; $display("FAIL reset_idle: state=%0d issue=%b expected 0/0", bus.state, bus.macIssue);
    end
  endtask

  task automatic test_load_and_issue();
    tick(1, 0, 16'h3FC0, 32'h0);
    tick(1, 0, 16'h0000, 32'h0);
    tick(1, 0, 16'h4000, 32'h0);
    tick(1, 0, 16'h0000, 32'h0);
    checks++;
    if (bus.opA !== 32'h3FC00000 || bus.opB !== 32'h40000000) begin
      failures++; $display("FAIL load_operands: opA=%h opB=%h expected 3fc00000/40000000", bus.opA, bus.opB);
    end
    checks++;
    if (bus.macIssue !== 1'b1 || bus.state !== 3'd4 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL issue_strobe: issue=%b state=%0d busy=%b expected 1/4/1", bus.macIssue, bus.state, bus.busy);
    end
    for (int k = 1; k <= LAT; k++) begin
      tick(0, 0, 16'h0, 32'hDEAD_BEEF ^ 32'(k));
      checks++;
      if (bus.resultValid !== 1'b0 || bus.busy !== 1'b1 || bus.macIssue !== 1'b0) begin
        failures++; $display("FAIL wait_cycle%0d: valid=%b busy=%b issue=%b expected 0/1/0", k, bus.resultValid, bus.busy, bus.macIssue);
      end
    end
    tick(0, 0, 16'h0, 32'h40400000);
    checks++;
    if (bus.resultReg !== 32'h40400000 || bus.resultValid !== 1'b1 || bus.busy !== 1'b0 || bus.state !== 3'd6) begin
      failures++; $display("FAIL result_capture: res=%h valid=%b busy=%b state=%0d expected 40400000/1/0/6",
                           bus.resultReg, bus.resultValid, bus.busy, bus.state);
    end
    tick(0, 0, 16'h0, 32'hFFFF_FFFF);
    checks++;
    if (bus.resultReg !== 32'h40400000 || bus.state !== 3'd6) begin
      failures++; $display("FAIL result_hold: res=%h state=%0d expected 40400000/6", bus.resultReg, bus.state);
    end
  endtask

  task automatic test_abort_wait();
    bit seen_valid = 0, seen_clr = 0;
    tick(0, 1, 16'h0, 32'h0);
    checks++;
    if (bus.accClear !== 1'b1 || bus.state !== 3'd0 || bus.resultValid !== 1'b0 || bus.resultReg !== 32'h0) begin
      failures++; $display("FAIL clear_from_done: clr=%b state=%0d valid=%b res=%h expected 1/0/0/0",
                           bus.accClear, bus.state, bus.resultValid, bus.resultReg);
    end
    for (int i = 0; i < 4; i++) tick(1, 0, 16'($urandom), 32'h0);
    repeat (3) tick(0, 0, 16'h0, $urandom);
    checks++;
    if (bus.state !== 3'd5) begin
      failures++; $display("FAIL third_wait: state=%0d expected 5", bus.state);
    end
    tick(0, 1, 16'h0, $urandom);
    checks++;
    if (bus.state !== 3'd0 || bus.accClear !== 1'b1 || bus.opA !== 32'h0 || bus.opB !== 32'h0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL abort: state=%0d clr=%b opA=%h opB=%h busy=%b expected 0/1/0/0/0",
                           bus.state, bus.accClear, bus.opA, bus.opB, bus.busy);
    end
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 16'h0, $urandom);
      if (bus.resultValid) seen_valid = 1;
      if (bus.accClear)    seen_clr   = 1;
    end
    checks++;
    if (seen_valid || seen_clr || bus.resultReg !== 32'h0 || bus.state !== 3'd0) begin
      failures++; $display("FAIL abort_no_result: valid_seen=%b clr_seen=%b res=%h state=%0d expected 0/0/0/0",
                           seen_valid, seen_clr, bus.resultReg, bus.state);
    end
  endtask

  task automatic test_enter_clear_same();
    tick(1, 0, 16'h1111, 32'h0);
    tick(1, 0, 16'h2222, 32'h0);
    tick(1, 0, 16'h3333, 32'h0);
    checks++;
    if (bus.state !== 3'd3 || bus.opB !== 32'h33330000) begin
      failures++; $display("FAIL reach_b_lo: state=%0d opB=%h expected 3/33330000", bus.state, bus.opB);
    end
    tick(1, 1, 16'hABCD, 32'h0);
    checks++;
    if (bus.state !== 3'd0 || bus.opB !== 32'h0 || bus.opA !== 32'h0 || bus.accClear !== 1'b1 || bus.macIssue !== 1'b0) begin
      failures++; $display("FAIL clear_wins: state=%0d opA=%h opB=%h clr=%b issue=%b expected 0/0/0/1/0",
                           bus.state, bus.opA, bus.opB, bus.accClear, bus.macIssue);
    end
  endtask

  task automatic test_enter_ignored();
    int issues = 0;
    tick(1, 0, 16'h3F80, 32'h0);
    tick(1, 0, 16'h0000, 32'h0);
    tick(1, 0, 16'h4120, 32'h0);
    tick(1, 0, 16'h0000, 32'h0);
    for (int i = 0; i <= LAT; i++) begin
      tick(1, 0, 16'($urandom_range(1, 16'hFFFF)), 32'h3F800000);
      if (bus.macIssue) issues++;
    end
    checks++;
    if (bus.opA !== 32'h3F800000 || bus.opB !== 32'h41200000 || issues !== 0) begin
      failures++; $display("FAIL enter_while_busy: opA=%h opB=%h extra_issues=%0d expected 3f800000/41200000/0",
                           bus.opA, bus.opB, issues);
    end
    checks++;
    if (bus.state !== 3'd6 || bus.resultReg !== 32'h3F800000) begin
      failures++; $display("FAIL busy_enter_done: state=%0d res=%h expected 6/3f800000", bus.state, bus.resultReg);
    end
  endtask

  task automatic test_chain_and_async_reset();
    bit seen_clr = 0;
    tick(1, 0, 16'h4000, 32'h0);
    if (bus.accClear) seen_clr = 1;
    checks++;
    if (bus.state !== 3'd1 || bus.resultValid !== 1'b0 || bus.opA !== 32'h40000000 || bus.opB !== 32'h41200000) begin
      failures++; $display("FAIL done_enter: state=%0d valid=%b opA=%h opB=%h expected 1/0/40000000/41200000",
                           bus.state, bus.resultValid, bus.opA, bus.opB);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 16'h0000, 32'h0);
      if (bus.accClear) seen_clr = 1;
    end
    checks++;
    if (bus.macIssue !== 1'b1 || seen_clr) begin
      failures++; $display("FAIL chain_issue: issue=%b clr_seen=%b expected 1/0", bus.macIssue, seen_clr);
    end
    tick(0, 0, 16'h0, 32'h0);
    tick(0, 0, 16'h0, 32'h0);
    reset = 1'b0;
    #1;
    checks++;
    if (dut_pack() !== '0) begin
      failures++; $display("FAIL async_reset_now: got %h expected 0", dut_pack());
    end
    @(posedge clock); #1;
    checks++;
    if (dut_pack() !== '0) begin
      failures++; $display("FAIL async_reset_hold: got %h expected 0", dut_pack());
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    bit e, c;
    for (int i = 0; i < 600; i++) begin
      e = ($urandom_range(0, 99) < 35);
      c = ($urandom_range(0, 99) < 3);
      tick(e, c, 16'($urandom), $urandom);
      checks++;
      if (dut_pack() !== m_pack()) begin
        failures++; $display("FAIL random_cycle%0d: got %h expected %h", i, dut_pack(), m_pack());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_and_issue();
    test_abort_wait();
    test_enter_clear_same();
    test_enter_ignored();
    test_chain_and_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
